out_port_arbiter: RTL and testbench

//  Shares the single 8-bit output port o_out of top between N_REQ internal requesters.

---
 rtl/out_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_out_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/out_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : out_port_arbiter                                                  |
// | Desc   : Shares one output byte port between N_REQ requesters; each        |
// |          accepted byte is held with o_out_valid for HOLD_CYCLES cycles.    |
// |          Define OUT_ARB_FIXED_PRIO_EN for fixed priority (lowest index     |
// |          wins) instead of the default round robin.                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module out_port_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]  i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [DATA_W-1:0]        o_out,
  output logic                     o_out_valid,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id,
  output logic                     o_busy
);

  localparam int c_GID_W = $clog2(N_REQ);
  localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_GID_W-1:0] c_LAST_ID  = c_GID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   c_ONE      = N_REQ'(1);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_HOLD = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               valid_q, valid_d;
  logic [c_GID_W-1:0] gnt_q, gnt_d;

  logic               w_any;
  logic               w_win_open;
  logic               w_accept;
  logic [c_GID_W-1:0] w_win_id;

  assign w_any      = |i_req_valid;
  assign w_win_open = (state_q == c_ST_IDLE) || (cnt_q == '0);
  assign w_accept   = w_win_open && w_any && !i_rst;

`ifdef OUT_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest valid index is the last (winning) assignment.
  always_comb begin
    w_win_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) w_win_id = c_GID_W'(i);
    end
  end
`else
  logic [c_GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               w_found;
  logic [c_GID_W-1:0] w_idx;

  // First valid requester at or after rr_ptr, wrapping N_REQ-1 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_win_id = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = c_GID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = w_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_accept) begin
      rr_ptr_d = (w_win_id == c_LAST_ID) ? '0 : (w_win_id + c_GID_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    gnt_d   = gnt_q;
    if (w_win_open) begin
      if (w_any) begin
        state_d = c_ST_HOLD;
        cnt_d   = c_CNT_LOAD;
        out_d   = i_req_data[int'(w_win_id)*DATA_W +: DATA_W];
        valid_d = 1'b1;
        gnt_d   = w_win_id;
      end else begin
        // Port goes quiet but keeps showing the last byte.
        state_d = c_ST_IDLE;
        valid_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q - c_CNT_W'(1);
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready = c_ONE << w_win_id;
    o_busy = (state_q == c_ST_HOLD);
  end

  assign o_out       = out_q;
  assign o_out_valid = valid_q;
  assign o_gnt_id    = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_out_port_arbiter                                               |
// | Desc   : Directed self-checking bench for out_port_arbiter (HOLD=4 and a   |
// |          second HOLD=1 instance).                                          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_out_port_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic [1:0]  gnt_id;
  logic        busy;

  logic [3:0]  h_valid;
  logic [31:0] h_data;
  logic [3:0]  h_ready;
  logic [7:0]  h_out;
  logic        h_out_valid;
  logic [1:0]  h_gnt_id;
  logic        h_busy;

  int checks;
  int errors;

  out_port_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_out(out), .o_out_valid(out_valid),
    .o_gnt_id(gnt_id), .o_busy(busy)
  );

  out_port_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(1)) dut_h1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(h_valid), .i_req_data(h_data),
    .o_req_ready(h_ready), .o_out(h_out), .o_out_valid(h_out_valid),
    .o_gnt_id(h_gnt_id), .o_busy(h_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0;
    step(); step();
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got %0d want 0", gnt_id); end
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ready_in_reset got %b want 0000", req_ready); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0010; req_data[15:8] = 8'hA5;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (out !== 8'hA5 || gnt_id !== 2'd1 || out_valid !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL single_accept got out=%h gnt=%0d v=%b busy=%b want A5 1 1 1", out, gnt_id, out_valid, busy); end
    for (int j = 1; j < 4; j++) begin
      step();
      checks++; if (out_valid !== 1'b1 || req_ready !== 4'b0000)
        begin errors++; $display("FAIL single_hold%0d got v=%b ready=%b want 1 0000", j, out_valid, req_ready); end
    end
    step();
    checks++; if (out_valid !== 1'b0 || out !== 8'hA5 || busy !== 1'b0)
      begin errors++; $display("FAIL single_end got v=%b out=%h busy=%b want 0 A5 0", out_valid, out, busy); end
  endtask

  task automatic test_rr_order();
    logic [1:0] exp_id [3];
    logic [7:0] exp_dat [3];
    exp_id  = '{2'd0, 2'd2, 2'd3};
    exp_dat = '{8'h11, 8'h22, 8'h33};
    do_reset();
    req_data  = {8'h33, 8'h22, 8'h00, 8'h11};
    req_valid = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id[k]))
        begin errors++; $display("FAIL order_ready%0d got %b want id %0d", k, req_ready, exp_id[k]); end
      step();
      req_valid[exp_id[k]] = 1'b0;
      checks++; if (gnt_id !== exp_id[k] || out !== exp_dat[k] || out_valid !== 1'b1)
        begin errors++; $display("FAIL order_grant%0d got gnt=%0d out=%h v=%b want %0d %h 1", k, gnt_id, out, out_valid, exp_id[k], exp_dat[k]); end
      for (int j = 1; j < 4; j++) begin
        step();
        checks++; if (out_valid !== 1'b1)
          begin errors++; $display("FAIL order_valid%0d_%0d got %b want 1", k, j, out_valid); end
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_end got v=%b want 0", out_valid); end
  endtask

  task automatic test_all_valid();
    logic [1:0] exp_id;
    do_reset();
    req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
`ifdef OUT_ARB_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = 2'(k % 4);
`endif
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id))
        begin errors++; $display("FAIL all_ready%0d got %b want id %0d", k, req_ready, exp_id); end
      step();
      checks++; if (gnt_id !== exp_id || out !== (8'hC0 | 8'(exp_id)))
        begin errors++; $display("FAIL all_grant%0d got gnt=%0d out=%h want id %0d", k, gnt_id, out, exp_id); end
      step(); step(); step();
    end
    req_valid = '0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL all_end got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    req_valid = 4'b1000; req_data = {8'h5A, 8'h00, 8'h00, 8'h00};
    step();
    req_valid = 4'b0010; req_data[15:8] = 8'h77;
    checks++; if (out !== 8'h5A || gnt_id !== 2'd3)
      begin errors++; $display("FAIL midrst_accept got out=%h gnt=%0d want 5A 3", out, gnt_id); end
    step(); step();
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1)
      begin errors++; $display("FAIL midrst_busy got ready=%b busy=%b want 0000 1", req_ready, busy); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready_rst got %b want 0000", req_ready); end
    step();
    checks++; if (out !== 8'h00 || out_valid !== 1'b0 || gnt_id !== 2'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_abort got out=%h v=%b gnt=%0d busy=%b want 00 0 0 0", out, out_valid, gnt_id, busy); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_pending_ready got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (out !== 8'h77 || gnt_id !== 2'd1 || out_valid !== 1'b1)
      begin errors++; $display("FAIL midrst_pending got out=%h gnt=%0d v=%b want 77 1 1", out, gnt_id, out_valid); end
    step(); step(); step(); step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes = '{8'h01, 8'h02, 8'h03};
    h_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      h_data[23:16] = bytes[k];
      #1;
      checks++; if (h_ready !== 4'b0100)
        begin errors++; $display("FAIL b2b_ready%0d got %b want 0100", k, h_ready); end
      step();
      checks++; if (h_out !== bytes[k] || h_out_valid !== 1'b1 || h_gnt_id !== 2'd2)
        begin errors++; $display("FAIL b2b_out%0d got out=%h v=%b gnt=%0d want %h 1 2", k, h_out, h_out_valid, h_gnt_id, bytes[k]); end
    end
    h_valid = '0;
    step();
    checks++; if (h_out_valid !== 1'b0 || h_out !== 8'h03)
      begin errors++; $display("FAIL b2b_end got v=%b out=%h want 0 03", h_out_valid, h_out); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; h_valid = '0; h_data = '0;
    test_reset();
    test_single();
    test_rr_order();
    test_all_valid();
    test_reset_mid_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
